hack_cpu_ctrl: RTL and testbench

Multi-cycle control and register stage that sits directly upstream of the 16-bit ALU. It fetches 16-bit instructions, holds the A, D and PC registers, and drives the ALU operands and control bits (zx, zy, nx, ny, no, f). It consumes the ALU result and flags for register and memory writeback and for jump evaluation. Instruction fetch and data memory use request/acknowledge handshakes that tolerate wait states.

---
 rtl/hack_cpu_pkg.sv | 40 ++++
 rtl/hack_jump_unit.sv | 15 +
 rtl/hack_cpu_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack CPU control stage: FSM states, instruction field
// positions, destination/jump bit indices and reset values.
package hack_cpu_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StMemRd,
        StExec,
        StMemWr
    } state_e;

    // Instruction word field positions
    localparam int unsigned IR_CI      = 15;
    localparam int unsigned IR_F_HI    = 14;
    localparam int unsigned IR_F_LO    = 13;
    localparam int unsigned IR_A       = 12;
    localparam int unsigned IR_ZX      = 11;
    localparam int unsigned IR_ZY      = 10;
    localparam int unsigned IR_NX      = 9;
    localparam int unsigned IR_NY      = 8;
    localparam int unsigned IR_NO      = 7;
    localparam int unsigned IR_RSVD    = 6;
    localparam int unsigned IR_DEST_HI = 5;
    localparam int unsigned IR_DEST_LO = 3;
    localparam int unsigned IR_JMP_HI  = 2;
    localparam int unsigned IR_JMP_LO  = 0;

    // Bit indices within the 3-bit dest and jump fields
    localparam int unsigned DEST_A = 2;
    localparam int unsigned DEST_D = 1;
    localparam int unsigned DEST_M = 0;
    localparam int unsigned JMP_LT = 2;
    localparam int unsigned JMP_EQ = 1;
    localparam int unsigned JMP_GT = 0;

    localparam int unsigned RST_PC   = 0;
    localparam int unsigned RST_WORD = 0;

endpackage

// File: rtl/hack_jump_unit.sv
// Jump condition evaluation from the C-instruction jump bits and the ALU flags.
module hack_jump_unit
    import hack_cpu_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    always_comb begin
        take = (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/register stage: fetches instructions, holds A/D/PC and
// drives the ALU operands and control bits, with handshaked instruction and data memory.
module hack_cpu_ctrl
    import hack_cpu_pkg::*;
#(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          instr_req,
    output logic [AW-1:0] instr_addr,
    input  logic [DW-1:0] instr_data,
    input  logic          instr_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic          zx,
    output logic          zy,
    output logic          nx,
    output logic          ny,
    output logic          no,
    output logic [1:0]    f,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zr,
    input  logic          alu_ng,
    output logic          retire
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] m_q;
    logic [DW-1:0] result_q;
    logic          zr_q;
    logic          ng_q;

    logic [2:0]    dest;
    logic [2:0]    jmp;
    logic          commit;
    logic [DW-1:0] wb_val;
    logic          jmp_zr;
    logic          jmp_ng;
    logic          take;
    logic [AW-1:0] pc_inc;
    logic          unused_rsvd;

    assign dest        = ir_q[IR_DEST_HI:IR_DEST_LO];
    assign jmp         = ir_q[IR_JMP_HI:IR_JMP_LO];
    assign unused_rsvd = ir_q[IR_RSVD];
    assign pc_inc      = pc_q + PC_ONE;

    assign instr_addr = pc_q;
    assign mem_addr   = a_q[AW-1:0];
    assign mem_wdata  = result_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[IR_A] ? m_q : a_q;
    assign zx         = ir_q[IR_ZX];
    assign zy         = ir_q[IR_ZY];
    assign nx         = ir_q[IR_NX];
    assign ny         = ir_q[IR_NY];
    assign no         = ir_q[IR_NO];
    assign f          = ir_q[IR_F_HI:IR_F_LO];

    // Commit straight from the ALU in EXEC, or from the latched result after a write.
    always_comb begin
        commit = 1'b0;
        wb_val = alu_out;
        jmp_zr = alu_zr;
        jmp_ng = alu_ng;
        if (state_q == StExec) begin
            commit = ~dest[DEST_M];
        end else if (state_q == StMemWr) begin
            commit = mem_ack;
            wb_val = result_q;
            jmp_zr = zr_q;
            jmp_ng = ng_q;
        end
    end

    hack_jump_unit u_jump (
        .j    (jmp),
        .zr   (jmp_zr),
        .ng   (jmp_ng),
        .take (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= AW'(RST_PC);
            a_q       <= DW'(RST_WORD);
            d_q       <= DW'(RST_WORD);
            ir_q      <= DW'(RST_WORD);
            m_q       <= DW'(RST_WORD);
            result_q  <= DW'(RST_WORD);
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            instr_req <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            retire    <= 1'b0;
        end else begin
            retire <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    // First FETCH after reset only raises the request.
                    if (!instr_req) begin
                        instr_req <= 1'b1;
                    end else if (instr_valid) begin
                        ir_q      <= instr_data;
                        instr_req <= 1'b0;
                        state_q   <= StDecode;
                    end
                end
                StDecode: begin
                    if (!ir_q[IR_CI]) begin
                        a_q       <= {1'b0, ir_q[DW-2:0]};
                        pc_q      <= pc_inc;
                        retire    <= 1'b1;
                        instr_req <= 1'b1;
                        state_q   <= StFetch;
                    end else if (ir_q[IR_A]) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state_q <= StMemRd;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StMemRd: begin
                    if (mem_ack) begin
                        m_q     <= mem_rdata;
                        mem_req <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q <= alu_out;
                    zr_q     <= alu_zr;
                    ng_q     <= alu_ng;
                    if (dest[DEST_M]) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state_q <= StMemWr;
                    end
                end
                StMemWr: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state_q <= StFetch;
            endcase

            // Jump target and mem_addr both use the pre-commit A.
            if (commit) begin
                if (dest[DEST_D]) d_q <= wb_val;
                if (dest[DEST_A]) a_q <= wb_val;
                pc_q      <= take ? a_q[AW-1:0] : pc_inc;
                retire    <= 1'b1;
                instr_req <= 1'b1;
                state_q   <= StFetch;
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed testbench for hack_cpu_ctrl with a reference ALU and wait-state memory models.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic [15:0] instr_data = '0;
    logic        instr_valid = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx, zy, nx, ny, no;
    logic [1:0]  f;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        retire;

    int checks = 0;
    int failures = 0;
    int ifetch_wait = 0;
    int mem_wait = 0;
    int icnt = 0;
    int dcnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int retire_cnt = 0;
    int rd_before_wr = 0;
    logic [14:0] rd_addr_log = '0;
    logic [14:0] wr_addr_log = '0;
    logic [15:0] wr_data_log = '0;
    logic [15:0] imem [64];
    logic [15:0] dmem [64];

    always #5 clk = ~clk;

    hack_cpu_ctrl #(.AW(15), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .instr_valid(instr_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .zx         (zx),
        .zy         (zy),
        .nx         (nx),
        .ny         (ny),
        .no         (no),
        .f          (f),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .retire     (retire)
    );

    // Reference ALU: f 00 add, 01 sub, 10 and, 11 or
    logic [15:0] m_x, m_y, m_o;
    always_comb begin
        m_x = zx ? 16'h0 : alu_x;
        if (nx) m_x = ~m_x;
        m_y = zy ? 16'h0 : alu_y;
        if (ny) m_y = ~m_y;
        case (f)
            2'b00:   m_o = m_x + m_y;
            2'b01:   m_o = m_x - m_y;
            2'b10:   m_o = m_x & m_y;
            default: m_o = m_x | m_y;
        endcase
        if (no) m_o = ~m_o;
    end
    assign alu_out = m_o;
    assign alu_zr  = (m_o == 16'h0);
    assign alu_ng  = m_o[15];

    // Instruction and data responders, driven on the falling edge
    always @(negedge clk) begin
        if (instr_req && icnt >= ifetch_wait) begin
            instr_valid = 1'b1;
            instr_data  = imem[instr_addr[5:0]];
        end else begin
            instr_valid = 1'b0;
        end
        icnt = instr_req ? icnt + 1 : 0;

        if (mem_req && dcnt >= mem_wait) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                dmem[mem_addr[5:0]] = mem_wdata;
                wr_addr_log = mem_addr;
                wr_data_log = mem_wdata;
                rd_before_wr = rd_cnt;
                wr_cnt++;
            end else begin
                mem_rdata = dmem[mem_addr[5:0]];
                rd_addr_log = mem_addr;
                rd_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
        end
        dcnt = mem_req ? dcnt + 1 : 0;

        if (retire) retire_cnt++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifetch_wait = 0;
        mem_wait = 0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = 16'h0000;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_and_wait_req(output bit tmo);
        rst_n = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (instr_req) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_retire(input int max_cyc, output int cyc, output bit tmo);
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit tmo;
        apply_reset();
        checks++;
        if ({instr_req, mem_req, mem_we, retire} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0000", {instr_req, mem_req, mem_we, retire});
        end
        checks++;
        if ({alu_x, alu_y, mem_addr, instr_addr} !== 62'h0) begin
            failures++;
            $display("FAIL reset_regs: got x=%h y=%h a=%h pc=%h want 0", alu_x, alu_y, mem_addr,
                     instr_addr);
        end
        release_and_wait_req(tmo);
        checks++;
        if (tmo !== 1'b0 || instr_addr !== 15'h0) begin
            failures++;
            $display("FAIL reset_first_fetch: got tmo=%0d pc=%h want 0 0000", tmo, instr_addr);
        end
    endtask

    task automatic test_a_instr();
        bit tmo;
        bit t2;
        int cyc;
        apply_reset();
        imem[0] = 16'h0005;
        release_and_wait_req(tmo);
        wait_retire(10, cyc, t2);
        checks++;
        if (tmo || t2 || cyc !== 2) begin
            failures++;
            $display("FAIL a_latency: got cyc=%0d tmo=%0d want 2", cyc, tmo | t2);
        end
        checks++;
        if (mem_addr !== 15'h0005 || instr_addr !== 15'h0001 || instr_req !== 1'b1) begin
            failures++;
            $display("FAIL a_load: got A=%h PC=%h req=%b want 0005 0001 1", mem_addr, instr_addr,
                     instr_req);
        end
    endtask

    task automatic test_c_dest_d();
        bit tmo;
        bit t2;
        bit t3;
        int cyc;
        apply_reset();
        imem[0] = 16'h0009;
        imem[1] = 16'h8810;
        release_and_wait_req(tmo);
        wait_retire(10, cyc, t2);
        @(negedge clk);
        checks++;
        if (f !== 2'b00 || {zx, zy, nx, ny, no} !== 5'b10000 || alu_x !== 16'h0 ||
            alu_y !== 16'h0009) begin
            failures++;
            $display("FAIL c_decode: got f=%b ctl=%b x=%h y=%h want 00 10000 0000 0009", f,
                     {zx, zy, nx, ny, no}, alu_x, alu_y);
        end
        wait_retire(10, cyc, t3);
        checks++;
        if (tmo || t2 || t3 || cyc + 1 !== 3) begin
            failures++;
            $display("FAIL c_latency: got cyc=%0d tmo=%0d want 3", cyc + 1, tmo | t2 | t3);
        end
        checks++;
        if (alu_x !== 16'h0009 || instr_addr !== 15'h0002 || mem_addr !== 15'h0009) begin
            failures++;
            $display("FAIL c_dest_d: got D=%h PC=%h A=%h want 0009 0002 0009", alu_x, instr_addr,
                     mem_addr);
        end
    endtask

    task automatic test_rmw();
        bit tmo;
        bit tacc;
        int cyc;
        int rd0;
        int wr0;
        apply_reset();
        imem[0] = 16'h0005;
        imem[1] = 16'h8810;
        imem[2] = 16'h0007;
        imem[3] = 16'h9008;
        dmem[7] = 16'h0003;
        release_and_wait_req(tacc);
        for (int i = 0; i < 3; i++) begin
            wait_retire(10, cyc, tmo);
            tacc |= tmo;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        wait_retire(20, cyc, tmo);
        checks++;
        if (tacc || tmo || cyc !== 5) begin
            failures++;
            $display("FAIL rmw_latency: got cyc=%0d tmo=%0d want 5", cyc, tacc | tmo);
        end
        checks++;
        if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1 || rd_before_wr !== rd0 + 1) begin
            failures++;
            $display("FAIL rmw_order: got rd=%0d wr=%0d rd_before_wr=%0d want 1 1 %0d",
                     rd_cnt - rd0, wr_cnt - wr0, rd_before_wr, rd0 + 1);
        end
        checks++;
        if (rd_addr_log !== 15'h7 || wr_addr_log !== 15'h7 || wr_data_log !== 16'h0008 ||
            dmem[7] !== 16'h0008) begin
            failures++;
            $display("FAIL rmw_data: got ra=%h wa=%h wd=%h m=%h want 0007 0007 0008 0008",
                     rd_addr_log, wr_addr_log, wr_data_log, dmem[7]);
        end
        checks++;
        if (alu_x !== 16'h0005 || mem_addr !== 15'h0007 || instr_addr !== 15'h0004) begin
            failures++;
            $display("FAIL rmw_regs: got D=%h A=%h PC=%h want 0005 0007 0004", alu_x, mem_addr,
                     instr_addr);
        end
    endtask

    task automatic test_jump();
        bit tacc;
        bit tmo;
        int cyc;
        apply_reset();
        imem[0]  = 16'h0010;
        imem[1]  = 16'h8C02;
        imem[16] = 16'h8C01;
        release_and_wait_req(tacc);
        wait_retire(10, cyc, tmo);
        tacc |= tmo;
        wait_retire(10, cyc, tmo);
        checks++;
        if (tacc || tmo || instr_addr !== 15'h0010) begin
            failures++;
            $display("FAIL jeq_taken: got PC=%h tmo=%0d want 0010", instr_addr, tacc | tmo);
        end
        wait_retire(10, cyc, tmo);
        checks++;
        if (tmo || instr_addr !== 15'h0011 || mem_addr !== 15'h0010) begin
            failures++;
            $display("FAIL jgt_not_taken: got PC=%h A=%h want 0011 0010", instr_addr, mem_addr);
        end
    endtask

    task automatic test_jmp_dest_a();
        bit tacc;
        bit tmo;
        int cyc;
        apply_reset();
        imem[0] = 16'h0020;
        imem[1] = 16'h8C27;
        release_and_wait_req(tacc);
        wait_retire(10, cyc, tmo);
        tacc |= tmo;
        wait_retire(10, cyc, tmo);
        checks++;
        if (tacc || tmo || instr_addr !== 15'h0020 || mem_addr !== 15'h0000) begin
            failures++;
            $display("FAIL jmp_old_a: got PC=%h A=%h want 0020 0000", instr_addr, mem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        bit tacc;
        bit tmo;
        int cyc;
        apply_reset();
        imem[0]  = 16'h7FFF;
        imem[1]  = 16'h8C07;
        imem[63] = 16'h0001;
        release_and_wait_req(tacc);
        wait_retire(10, cyc, tmo);
        tacc |= tmo;
        wait_retire(10, cyc, tmo);
        checks++;
        if (tacc || tmo || instr_addr !== 15'h7FFF) begin
            failures++;
            $display("FAIL jmp_to_top: got PC=%h want 7fff", instr_addr);
        end
        wait_retire(10, cyc, tmo);
        checks++;
        if (tmo || instr_addr !== 15'h0000 || mem_addr !== 15'h0001) begin
            failures++;
            $display("FAIL pc_wrap: got PC=%h A=%h want 0000 0001", instr_addr, mem_addr);
        end
    endtask

    task automatic test_fetch_wait();
        bit tmo;
        bit t2;
        bit stable;
        int cyc;
        apply_reset();
        imem[0] = 16'h0005;
        ifetch_wait = 3;
        release_and_wait_req(tmo);
        stable = instr_req && instr_addr == 15'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stable &= instr_req && instr_addr == 15'h0;
        end
        checks++;
        if (tmo || stable !== 1'b1) begin
            failures++;
            $display("FAIL fetch_wait_stable: got stable=%b tmo=%0d want 1", stable, tmo);
        end
        wait_retire(10, cyc, t2);
        checks++;
        if (t2 || cyc !== 2 || mem_addr !== 15'h0005) begin
            failures++;
            $display("FAIL fetch_wait_done: got cyc=%0d A=%h want 2 0005", cyc, mem_addr);
        end
    endtask

    task automatic test_reset_mid_write();
        bit tacc;
        bit tmo;
        int cyc;
        int rc0;
        int wc0;
        apply_reset();
        imem[0] = 16'h0007;
        imem[1] = 16'h8C08;
        mem_wait = 6;
        release_and_wait_req(tacc);
        wait_retire(10, cyc, tmo);
        tacc |= tmo;
        tmo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                tmo = 1'b0;
                break;
            end
        end
        checks++;
        if (tacc || tmo) begin
            failures++;
            $display("FAIL memwr_reached: got tmo=%0d want 0", tacc | tmo);
        end
        @(negedge clk);
        rc0 = retire_cnt;
        wc0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, instr_req, retire} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_abort: got req/we/ireq/ret=%b want 0000",
                     {mem_req, mem_we, instr_req, retire});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (retire_cnt !== rc0 || wr_cnt !== wc0) begin
            failures++;
            $display("FAIL reset_no_commit: got retires=%0d writes=%0d want %0d %0d", retire_cnt,
                     wr_cnt, rc0, wc0);
        end
        release_and_wait_req(tmo);
        checks++;
        if (tmo || instr_addr !== 15'h0 || mem_addr !== 15'h0) begin
            failures++;
            $display("FAIL reset_restart: got PC=%h A=%h tmo=%0d want 0000 0000", instr_addr,
                     mem_addr, tmo);
        end
    endtask

    initial begin
        test_reset();
        test_a_instr();
        test_c_dest_d();
        test_rmw();
        test_jump();
        test_jmp_dest_a();
        test_pc_wrap();
        test_fetch_wait();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
